// File: rtl/ulpi_rx_decoder.sv
// ulpi_rx_decoder: passive decoder for the PHY-driven half of the ULPI bus.
// It follows dir/nxt turnaround and sorts each PHY byte into one of three
// kinds: RX CMD status, USB receive data or register-read data. Received
// packet bytes leave through a one-byte hold, so eop can be attached to the
// final byte.
module ulpi_rx_decoder #(
  parameter int unsigned MAX_PKT_BYTES = 1027,
  parameter int unsigned LEN_W         = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_dir,
  input  logic             i_nxt,
  input  logic [7:0]       i_data,
  input  logic             i_reg_rd_pending,
  output logic [1:0]       o_linestate,
  output logic [1:0]       o_vbus_state,
  output logic             o_rx_active,
  output logic             o_host_disconnect,
  output logic             o_id,
  output logic             o_alt_int,
  output logic             o_rxcmd_valid,
  output logic [7:0]       o_pkt_data,
  output logic             o_pkt_valid,
  output logic             o_pkt_sop,
  output logic             o_pkt_eop,
  output logic             o_pkt_err,
  output logic [LEN_W-1:0] o_pkt_len,
  output logic [7:0]       o_reg_data,
  output logic             o_reg_valid,
  output logic             o_reg_abort
);

  localparam logic [LEN_W-1:0] LP_MAX = LEN_W'(MAX_PKT_BYTES);
  localparam logic [LEN_W-1:0] LP_SAT = LEN_W'(MAX_PKT_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN_IN,
    S_RX_CMD_DATA,
    S_REG_DATA,
    S_TURN_OUT
  } state_t;

  state_t           r_state;
  logic             r_pkt_open;
  logic             r_err;
  logic [LEN_W-1:0] r_len;
  logic [7:0]       r_hold;
  logic             r_hold_vld;
  logic             r_first;

  logic             w_in_rx;
  logic [1:0]       w_ev;
  logic             w_rxcmd;
  logic             w_byte;
  logic             w_new_active;
  logic             w_open_implicit;
  logic             w_dir_lost;
  logic             w_close;
  logic             w_close_err;

  // Classify the current bus cycle and decide whether the open packet closes.
  always_comb begin
    w_in_rx         = (r_state == S_RX_CMD_DATA);
    w_ev            = i_data[5:4];
    w_rxcmd         = w_in_rx && i_dir && !i_nxt;
    w_byte          = w_in_rx && i_dir && i_nxt;
    // RxEvent 01 and 11 mean "receive active"; 00 and 10 mean it is not.
    w_new_active    = w_ev[0];
    w_open_implicit = (r_state == S_IDLE) && i_dir && i_nxt;
    w_dir_lost      = r_pkt_open && !i_dir &&
                      ((r_state == S_TURN_IN) || w_in_rx);
    // A falling dir edge cannot carry data, so a close always takes priority
    // over a byte arriving on the same edge.
    w_close         = w_dir_lost ||
                      (r_pkt_open && w_rxcmd && o_rx_active && !w_new_active);
    w_close_err     = r_err || w_dir_lost;
  end

  // Bus FSM with its registered status, register-read and abort outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state           <= S_IDLE;
      o_linestate       <= 2'b00;
      o_vbus_state      <= 2'b00;
      o_rx_active       <= 1'b0;
      o_host_disconnect <= 1'b0;
      o_id              <= 1'b0;
      o_alt_int         <= 1'b0;
      o_rxcmd_valid     <= 1'b0;
      o_reg_data        <= '0;
      o_reg_valid       <= 1'b0;
      o_reg_abort       <= 1'b0;
    end else begin
      o_rxcmd_valid <= 1'b0;
      o_reg_valid   <= 1'b0;
      o_reg_abort   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_dir) begin
            r_state <= S_TURN_IN;
            if (i_nxt) begin
              o_rx_active <= 1'b1;
              o_reg_abort <= i_reg_rd_pending;
            end
          end
        end
        S_TURN_IN: begin
          if (!i_dir) begin
            r_state <= S_IDLE;
            if (w_dir_lost) o_rx_active <= 1'b0;
          end else if (i_reg_rd_pending && !r_pkt_open) begin
            r_state <= S_REG_DATA;
          end else begin
            r_state <= S_RX_CMD_DATA;
          end
        end
        S_REG_DATA: begin
          if (!i_dir) begin
            r_state <= S_IDLE;
          end else begin
            o_reg_data  <= i_data;
            o_reg_valid <= 1'b1;
            r_state     <= S_RX_CMD_DATA;
          end
        end
        S_RX_CMD_DATA: begin
          if (!i_dir) begin
            r_state <= S_TURN_OUT;
            if (w_dir_lost) o_rx_active <= 1'b0;
          end else if (!i_nxt) begin
            o_linestate       <= i_data[1:0];
            o_vbus_state      <= i_data[3:2];
            o_id              <= i_data[6];
            o_alt_int         <= i_data[7];
            o_rx_active       <= w_new_active;
            o_host_disconnect <= (w_ev == 2'b10);
            o_rxcmd_valid     <= 1'b1;
          end
        end
        S_TURN_OUT: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Packet framing: one-byte hold, length count, error latch and beat output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pkt_open  <= 1'b0;
      r_err       <= 1'b0;
      r_len       <= '0;
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_first     <= 1'b0;
      o_pkt_data  <= '0;
      o_pkt_valid <= 1'b0;
      o_pkt_sop   <= 1'b0;
      o_pkt_eop   <= 1'b0;
      o_pkt_err   <= 1'b0;
      o_pkt_len   <= '0;
    end else begin
      o_pkt_valid <= 1'b0;
      o_pkt_sop   <= 1'b0;
      o_pkt_eop   <= 1'b0;
      o_pkt_err   <= 1'b0;
      o_pkt_len   <= '0;
      if (w_close) begin
        if (r_hold_vld) begin
          o_pkt_data  <= r_hold;
          o_pkt_valid <= 1'b1;
          o_pkt_sop   <= r_first;
          o_pkt_eop   <= 1'b1;
          o_pkt_err   <= w_close_err;
          o_pkt_len   <= r_len;
        end
        r_err      <= w_close_err;
        r_pkt_open <= 1'b0;
        r_hold_vld <= 1'b0;
        r_first    <= 1'b0;
      end else if (w_open_implicit) begin
        r_pkt_open <= 1'b1;
        r_err      <= 1'b0;
        r_len      <= '0;
        r_hold_vld <= 1'b0;
        r_first    <= 1'b1;
      end else if (w_byte) begin
        if (!r_pkt_open) begin
          r_pkt_open <= 1'b1;
          r_err      <= 1'b0;
          r_len      <= LEN_W'(1);
          r_hold     <= i_data;
          r_hold_vld <= 1'b1;
          r_first    <= 1'b1;
        end else if (r_len < LP_MAX) begin
          if (r_hold_vld) begin
            o_pkt_data  <= r_hold;
            o_pkt_valid <= 1'b1;
            o_pkt_sop   <= r_first;
            r_first     <= 1'b0;
          end
          r_hold     <= i_data;
          r_hold_vld <= 1'b1;
          r_len      <= r_len + 1'b1;
        end else begin
          // Past the limit: the last accepted byte stays held for eop and
          // extra bytes are only counted (saturating).
          r_len <= LP_SAT;
          r_err <= 1'b1;
        end
      end else if (w_rxcmd && (w_ev == 2'b11)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ulpi_rx_decoder.md
Name: ulpi_rx_decoder

Overview:
Passive decoder on the PHY-to-link half of the ULPI bus, alongside ulpi_ctrl on the same i_clk (60 MHz ULPI clock). Tracks dir/nxt turnaround and classifies every PHY-driven byte as RX CMD, USB receive data or register-read data. Publishes registered line/VBUS status, a framed USB packet byte stream (sop/eop/err) and register read results to the link-layer logic.

Parameters:
MAX_PKT_BYTES, 1027, packet byte limit (PID + 1024 payload + CRC16); the byte after the limit flags overflow.
LEN_W, 11, width of the packet length counter; must hold MAX_PKT_BYTES + 1.

Ports:
i_clk  in  1  ULPI clock; all logic on rising edge.
i_rst  in  1  synchronous, active-high reset.
i_dir  in  1  ULPI dir from PHY.
i_nxt  in  1  ULPI nxt from PHY.
i_data  in  8  ULPI data bus, as sampled.
i_reg_rd_pending  in  1  level from ulpi_ctrl: register read command accepted, data not yet returned.
o_linestate  out  2  last RX CMD [1:0].
o_vbus_state  out  2  last RX CMD [3:2].
o_rx_active  out  1  USB receive in progress.
o_host_disconnect  out  1  RxEvent == 2'b10 in last RX CMD.
o_id  out  1  last RX CMD [6].
o_alt_int  out  1  last RX CMD [7].
o_rxcmd_valid  out  1  one-cycle pulse: status outputs just updated.
o_pkt_data  out  8  packet byte.
o_pkt_valid  out  1  o_pkt_data valid this cycle.
o_pkt_sop  out  1  first byte of packet (qualified by valid).
o_pkt_eop  out  1  last byte of packet (qualified by valid).
o_pkt_err  out  1  with eop: RxError seen, overflow or dir dropped mid-packet.
o_pkt_len  out  LEN_W  byte count of packet; valid with eop.
o_reg_data  out  8  register read result.
o_reg_valid  out  1  one-cycle pulse with o_reg_data.
o_reg_abort  out  1  one-cycle pulse: PHY preempted a pending read with USB receive.

Behaviour:
- Reset: all outputs 0; o_linestate 2'b00; FSM to IDLE; hold register empty; err latch and len counter cleared. Reset mid-packet drops the packet, no eop emitted.
- FSM states: IDLE, TURN_IN, RX_CMD_DATA, REG_DATA, TURN_OUT.
- IDLE: dir 0→1 goes to TURN_IN. If i_nxt=1 on that same edge, this is an implicit RxActive=1: o_rx_active<=1 and a new packet opens. If i_reg_rd_pending=1 as well, pulse o_reg_abort.
- TURN_IN: one cycle; i_data ignored. Next state is REG_DATA if i_reg_rd_pending=1 and no implicit RxActive; otherwise RX_CMD_DATA. If dir is already 0, go to IDLE.
- REG_DATA: o_reg_data<=i_data, o_reg_valid pulse next cycle, then RX_CMD_DATA. If dir=0 here, no reg pulse; go to IDLE.
- RX_CMD_DATA with dir=1, nxt=0: RX CMD byte. At the next edge, update the status outputs and pulse o_rxcmd_valid.
  - RxEvent [5:4]: 00 → rx_active 0; 01 → rx_active 1; 11 → rx_active 1 and err latch set; 10 → host_disconnect 1, rx_active 0.
  - A 1→0 transition of rx_active closes the open packet.
- RX_CMD_DATA with dir=1, nxt=1: packet byte. If no packet is open, open one (sop on its first byte). The previous held byte is emitted and the new byte is held.
- dir falls in RX_CMD_DATA: go to TURN_OUT (1 cycle, data ignored), then IDLE. If a packet is open: rx_active<=0, err latch set, packet closed.
- Packet output uses a one-byte hold so eop tags the final byte.
  - Each held byte is emitted with valid=1 when the next packet byte arrives (eop=0), or when the packet closes (eop=1, err=latch, len=count).
  - Emission is 1 cycle after the later of those events.
  - sop is set on the first emitted byte. A single-byte packet has sop=eop=1.
  - A packet closed with zero bytes emits nothing.
- Length counter: saturates at MAX_PKT_BYTES+1. Reaching it sets the err latch; further bytes are counted as dropped (not emitted).
- Simultaneous close and new byte on the same edge (dir drop cannot carry data): the close wins; that cycle's data is ignored.
- The err latch and counter clear when the next packet opens.
- No backpressure: the consumer must accept o_pkt_valid every cycle.

Test Plan:
- Reset then dir 0→1, nxt=0, data 8'h4D, dir 0 → o_rxcmd_valid once; linestate=01, vbus=11, rx_active=0, id=1, alt_int=0.
- Packet: dir↑ with nxt=1, then bytes C3,01,02,AA,BB (nxt=1), RX CMD 8'h00, dir↓ → 5 valid beats C3..BB; sop on C3; eop on BB; err=0; len=5.
- Register read: pending=1, dir↑ nxt=0, turnaround, data 8'h5A, dir↓ → o_reg_valid one cycle with 8'h5A; o_rxcmd_valid not pulsed for that byte.
- Preempted read: pending=1, dir↑ with nxt=1, bytes 69,10 → o_reg_abort pulse; packet 69,10 emitted with sop/eop; no o_reg_valid.
- Error: packet C3,11, RX CMD 8'h30, then 8'h00 → eop on 11 with err=1, len=2. Separately, dir dropping after byte 22 → eop on 22 with err=1.
- Overflow: 1030 data bytes → 1027 bytes emitted; eop on the last emitted byte with err=1; o_pkt_len=1028; i_rst mid-packet → no eop emitted, all outputs 0 next cycle.
